blake_round_ctrl: RTL
=====================

# blake_round_ctrl

Sequencer for the 2-G-unit BLAKE-512 compression core. It accepts a start request and pulses `init` to load the IV into the state-register bank. It then steps `ena` through every G-function step of every round and signals finalization and completion. Step/round/sigma indices drive the G-unit operand muxes and message-permutation selection.

## Interface
Parameters:
- `ROUNDS`, default 16: compression rounds per block; legal range 1..31.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request one compression; sampled only in IDLE.
- `busy`  out  1: high from INIT through FINAL inclusive.
- `done`  out  1: one-cycle completion pulse.
- `init`  out  1: load IV into state registers (drives register-bank `init`).
- `ena`  out  1: advance state registers with G-unit outputs (drives register-bank `ena`).
- `fin`  out  1: one-cycle pulse; enables the output-XOR finalization register.
- `round`  out  5: current round, 0..ROUNDS-1.
- `sigma_idx`  out  4: round mod 10; selects message permutation.
- `step`  out  2: G step within round, 0..3.
- `diag`  out  1: equals `step[1]`; 0 = column phase, 1 = diagonal phase.
- `abort`  in  1: present only with `BLAKE_CTRL_ABORT_EN`.

## Operation
- FSM states: IDLE → INIT → RUN → FINAL → DONE → IDLE.
- IDLE: `start`=1 → INIT; otherwise stay.
- INIT: one cycle, `init`=1, counters cleared → RUN.
- RUN: `ena`=1 every cycle. `step` increments 0..3. On `step`=3:
  - `step` wraps to 0 and `round` increments.
  - `sigma_idx` increments, wrapping 9→0 via an independent wrap counter; no divider.
- RUN exit: at `round`=ROUNDS-1 and `step`=3 → FINAL.
- FINAL: one cycle, `fin`=1 → DONE.
- DONE: one cycle, `done`=1, `busy`=0 → IDLE.
- Per round: 2 column steps (2 G each) and 2 diagonal steps (2 G each), i.e. 8 G evaluations.
- All outputs are registered (Moore). `round`, `sigma_idx`, `step` and `diag` are valid whenever `ena`=1. They hold their last values in FINAL and DONE, and clear in INIT.
- `init`, `ena` and `fin` are mutually exclusive; never two high in one cycle.
- `start` outside IDLE (including DONE) is ignored; it is neither queued nor counted.
- Reset values: state IDLE; `busy`, `done`, `init`, `ena` and `fin` = 0; `round`, `sigma_idx` and `step` = 0; `diag` = 0.
- Reset mid-operation: state returns to IDLE at the next edge with all outputs at reset values; no `done` or `fin` is issued.

## Timing
- `start` high at edge k in IDLE gives:
  - INIT in cycle k+1;
  - RUN in cycles k+2 .. k+1+4·ROUNDS;
  - FINAL in cycle k+2+4·ROUNDS;
  - DONE in cycle k+3+4·ROUNDS.
- Defaults: `ena` asserted 64 cycles; start-to-`done` latency 67 cycles.
- Back-to-back: earliest next accepted `start` is in the IDLE cycle following DONE, so throughput is one block per 4·ROUNDS+4 cycles.
- ROUNDS=1: RUN lasts exactly 4 cycles; `round` stays 0.
- `sigma_idx` sequence (ROUNDS=16): 0..9, 0..5.

## Configuration
- `BLAKE_CTRL_ABORT_EN` defined:
  - adds the `abort` input;
  - `abort`=1 in INIT, RUN or FINAL → IDLE at the next edge, with outputs at reset values and no `fin` or `done`;
  - `abort` in IDLE or DONE has no effect;
  - `abort` and `start` together in IDLE: `start` wins.
- `BLAKE_CTRL_ABORT_EN` undefined: no `abort` port; the sequence always completes unless `rst` is asserted.

## Test plan
- Reset, then idle 10 cycles → all outputs 0, `busy`=0.
- `start` pulse, ROUNDS=16 → `init` 1 cycle, then `ena` 64 consecutive cycles, `fin` at +66, `done` at +67. `round`/`step` walk (0,0)..(15,3); `sigma_idx` at round 10 = 0, at round 15 = 5; `diag`=1 only on steps 2 and 3.
- `start` held high continuously → compressions every 68 cycles; `start` during RUN and DONE is ignored.
- `rst` asserted in RUN at round 7, step 2 → next cycle all outputs 0 and IDLE; no `fin`/`done`; a fresh `start` then completes normally.
- ROUNDS=1 → `ena` exactly 4 cycles, `done` 7 cycles after `start`.
- With `BLAKE_CTRL_ABORT_EN`: `abort` in RUN at round 3 → IDLE next cycle, no `done`. `abort` in DONE → `done` still a single-cycle pulse.

Source files
------------

// File: rtl/blake_round_ctrl.sv
// BLAKE-512 round sequencer: INIT, 4*ROUNDS RUN steps, FINAL, DONE; start-to-done 4*ROUNDS+3 cycles, no backpressure.
// Define BLAKE_CTRL_ABORT_EN to add an abort input that returns INIT/RUN/FINAL to IDLE.
module blake_round_ctrl #(
  parameter int unsigned ROUNDS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef BLAKE_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       done,
  output logic       init,
  output logic       ena,
  output logic       fin,
  output logic [4:0] round,
  output logic [3:0] sigma_idx,
  output logic [1:0] step,
  output logic       diag
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_round;
  logic [4:0] w_round_nxt;
  logic [3:0] r_sigma;
  logic [3:0] w_sigma_nxt;
  logic [1:0] r_step;
  logic [1:0] w_step_nxt;
  logic       r_busy;
  logic       r_done;
  logic       r_init;
  logic       r_ena;
  logic       r_fin;
  logic       w_last;
  logic       w_kill;

`ifdef BLAKE_CTRL_ABORT_EN
  assign w_kill = abort;
`else
  assign w_kill = 1'b0;
`endif

  assign w_last = (r_round == LAST_RND) && (r_step == 2'd3);

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_sigma_nxt = r_sigma;
    w_step_nxt  = r_step;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_INIT;
          w_round_nxt = 5'd0;
          w_sigma_nxt = 4'd0;
          w_step_nxt  = 2'd0;
        end
      end
      S_INIT: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_FINAL;
        end else begin
          w_step_nxt = r_step + 2'd1;
          if (r_step == 2'd3) begin
            w_round_nxt = r_round + 5'd1;
            // sigma wraps on its own counter so no mod-10 divider is needed
            w_sigma_nxt = (r_sigma == 4'd9) ? 4'd0 : r_sigma + 4'd1;
          end
        end
      end
      S_FINAL: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_kill && (r_state == S_INIT || r_state == S_RUN || r_state == S_FINAL)) begin
      w_state_nxt = S_IDLE;
      w_round_nxt = 5'd0;
      w_sigma_nxt = 4'd0;
      w_step_nxt  = 2'd0;
    end
  end

  // Strobes are registered from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_round <= 5'd0;
      r_sigma <= 4'd0;
      r_step  <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_init  <= 1'b0;
      r_ena   <= 1'b0;
      r_fin   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_sigma <= w_sigma_nxt;
      r_step  <= w_step_nxt;
      r_busy  <= (w_state_nxt == S_INIT) || (w_state_nxt == S_RUN) || (w_state_nxt == S_FINAL);
      r_done  <= (w_state_nxt == S_DONE);
      r_init  <= (w_state_nxt == S_INIT);
      r_ena   <= (w_state_nxt == S_RUN);
      r_fin   <= (w_state_nxt == S_FINAL);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign init      = r_init;
  assign ena       = r_ena;
  assign fin       = r_fin;
  assign round     = r_round;
  assign sigma_idx = r_sigma;
  assign step      = r_step;
  assign diag      = r_step[1];

endmodule
